fmc_slave_ctrl: RTL and testbench

- Slave-side controller for the external MCU FMC bus.
- Synchronises the asynchronous chip-select and strobes (fmc_ne1, fmc_noe, fmc_nwe) into the FPGA clock domain and sequences each FMC cycle into a single-outstanding internal register-bus request/acknowledge transaction.
- Holds fmc_nwait low while the internal target is busy, and aborts any transaction that exceeds a timeout.
- Sits between the top-level FMC pins and the FPGA register decoder.

---
 rtl/fmc_slave_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_fmc_slave_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_slave_ctrl.sv
// FMC slave-side controller: synchronises the MCU strobes and turns each FMC
// cycle into one request/acknowledge transaction on the internal register bus.
module fmc_slave_ctrl #(
    parameter int unsigned          ADDR_BITS      = 26,
    parameter int unsigned          DATA_BITS      = 32,
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 256,
    parameter logic [DATA_BITS-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fmc_ne1,
    input  logic                 fmc_noe,
    input  logic                 fmc_nwe,
    input  logic [ADDR_BITS-1:0] fmc_a,
    input  logic [DATA_BITS-1:0] fmc_d_in,
    output logic [DATA_BITS-1:0] fmc_d_out,
    output logic                 fmc_d_oe,
    output logic                 fmc_nwait,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic                 reg_wr,
    output logic                 reg_rd,
    input  logic [DATA_BITS-1:0] reg_rdata,
    input  logic                 reg_ack,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_RD_REQ,
        S_RD_DRIVE,
        S_WR_CAP,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_ne1_sync;
    logic [SYNC_STAGES-1:0] r_noe_sync;
    logic [SYNC_STAGES-1:0] r_nwe_sync;
    logic [SYNC_STAGES-1:0] r_primed;
    logic                   w_ne1_s;
    logic                   w_noe_s;
    logic                   w_nwe_s;
    logic                   w_sync_valid;

    logic [CNT_W-1:0]     r_cnt;
    logic                 w_cnt_last;

    logic [DATA_BITS-1:0] r_d_out;
    logic                 r_nwait;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 r_wr;
    logic                 r_rd;
    logic                 r_err;

    logic w_rd_issue;
    logic w_rd_ok;
    logic w_rd_to;
    logic w_wr_cap;
    logic w_wr_issue;
    logic w_wr_ok;
    logic w_wr_to;
    logic w_wr_strobe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ne1_sync <= '1;
            r_noe_sync <= '1;
            r_nwe_sync <= '1;
            r_primed   <= '0;
        end else begin
            r_ne1_sync <= {r_ne1_sync[SYNC_STAGES-2:0], fmc_ne1};
            r_noe_sync <= {r_noe_sync[SYNC_STAGES-2:0], fmc_noe};
            r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], fmc_nwe};
            r_primed   <= {r_primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_ne1_s      = r_ne1_sync[SYNC_STAGES-1];
    assign w_noe_s      = r_noe_sync[SYNC_STAGES-1];
    assign w_nwe_s      = r_nwe_sync[SYNC_STAGES-1];
    // The preset 1s are not real pin samples; RESYNC only trusts ne1_s once
    // the chain has been refilled from the pin after reset.
    assign w_sync_valid = r_primed[SYNC_STAGES-1];

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_wr_strobe = !w_ne1_s && (!w_noe_s || !w_nwe_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RESYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        w_rd_ok     = 1'b0;
        w_rd_to     = 1'b0;
        w_wr_cap    = 1'b0;
        w_wr_issue  = 1'b0;
        w_wr_ok     = 1'b0;
        w_wr_to     = 1'b0;
        case (r_state)
            S_RESYNC: begin
                if (w_sync_valid && w_ne1_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_ne1_s && !w_noe_s) begin
                    w_rd_issue  = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end else if (!w_ne1_s && !w_nwe_s) begin
                    w_state_nxt = S_WR_CAP;
                end
            end
            S_RD_REQ: begin
                if (reg_ack) begin
                    w_rd_ok     = 1'b1;
                    w_state_nxt = S_RD_DRIVE;
                end else if (w_cnt_last) begin
                    w_rd_to     = 1'b1;
                    w_state_nxt = S_RD_DRIVE;
                end
            end
            S_RD_DRIVE: begin
                if (w_noe_s || w_ne1_s) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WR_CAP: begin
                if (w_nwe_s) begin
                    w_wr_issue  = 1'b1;
                    w_state_nxt = S_WR_REQ;
                end else begin
                    w_wr_cap = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (reg_ack) begin
                    w_wr_ok     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_cnt_last) begin
                    w_wr_to     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_RESYNC;
            end
        endcase
    end

    // Saturating cycle counter; restarts whenever a request is launched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_rd_issue || w_wr_issue) begin
            r_cnt <= '0;
        end else if ((r_state == S_RD_REQ || r_state == S_WR_REQ) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_out <= '0;
            r_nwait <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_rd_issue) begin
                r_addr  <= fmc_a;
                r_rd    <= 1'b1;
                r_nwait <= 1'b0;
            end
            if (w_rd_ok) begin
                r_d_out <= reg_rdata;
                r_rd    <= 1'b0;
                r_nwait <= 1'b1;
            end
            if (w_rd_to) begin
                r_d_out <= TIMEOUT_DATA;
                r_rd    <= 1'b0;
                r_nwait <= 1'b1;
            end
            if (w_wr_cap) begin
                r_addr  <= fmc_a;
                r_wdata <= fmc_d_in;
            end
            if (w_wr_issue) begin
                r_wr <= 1'b1;
            end
            // Posted write: only stall the master if it starts another strobe.
            if (w_wr_ok || w_wr_to) begin
                r_wr    <= 1'b0;
                r_nwait <= 1'b1;
            end else if (r_state == S_WR_REQ && w_wr_strobe) begin
                r_nwait <= 1'b0;
            end
            if (r_state == S_DONE) begin
                r_nwait <= 1'b1;
            end
            if (w_rd_to || w_wr_to) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Pad enable uses the raw pins so the bus is released without sync delay.
    assign fmc_d_oe    = (r_state == S_RD_DRIVE) && !fmc_ne1 && !fmc_noe;
    assign fmc_d_out   = r_d_out;
    assign fmc_nwait   = r_nwait;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_wr      = r_wr;
    assign reg_rd      = r_rd;
    assign timeout_err = r_err;

    a_one_outstanding: assert property (@(posedge clk) disable iff (!reset) !(r_rd && r_wr));

endmodule

// File: tb/tb_fmc_slave_ctrl.sv
// Directed bench for fmc_slave_ctrl: a default instance for the transaction
// tests and an 8-cycle-timeout instance (never acked) for the abort tests.
module tb_fmc_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ne1, noe, nwe;
    logic [25:0] a;
    logic [31:0] din;
    logic [31:0] rdata_val;
    logic        err_clr;
    logic        ack_auto;
    logic        ack_force;
    logic        ack;

    logic [31:0] m_dout, t_dout;
    logic        m_doe, t_doe;
    logic        m_nwait, t_nwait;
    logic [25:0] m_addr, t_addr;
    logic [31:0] m_wdata, t_wdata;
    logic        m_wr, t_wr;
    logic        m_rd, t_rd;
    logic        m_err, t_err;

    int n_total = 0;
    int n_bad   = 0;

    int rd_dly = 3;
    int wr_dly = 2;
    int ack_cnt = 0;

    bit mon_en      = 1'b0;
    bit nw_lo_seen  = 1'b0;
    bit nw_lo_in_wr = 1'b0;
    bit both_seen   = 1'b0;
    int wr_len      = 0;

    always #5 clk = ~clk;

    assign ack = ack_auto | ack_force;

    fmc_slave_ctrl u_dut (
        .clk(clk), .reset(rst_n),
        .fmc_ne1(ne1), .fmc_noe(noe), .fmc_nwe(nwe),
        .fmc_a(a), .fmc_d_in(din),
        .fmc_d_out(m_dout), .fmc_d_oe(m_doe), .fmc_nwait(m_nwait),
        .reg_addr(m_addr), .reg_wdata(m_wdata), .reg_wr(m_wr), .reg_rd(m_rd),
        .reg_rdata(rdata_val), .reg_ack(ack),
        .timeout_err(m_err), .err_clr(err_clr)
    );

    fmc_slave_ctrl #(.TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .reset(rst_n),
        .fmc_ne1(ne1), .fmc_noe(noe), .fmc_nwe(nwe),
        .fmc_a(a), .fmc_d_in(din),
        .fmc_d_out(t_dout), .fmc_d_oe(t_doe), .fmc_nwait(t_nwait),
        .reg_addr(t_addr), .reg_wdata(t_wdata), .reg_wr(t_wr), .reg_rd(t_rd),
        .reg_rdata(32'h1234_5678), .reg_ack(1'b0),
        .timeout_err(t_err), .err_clr(err_clr)
    );

    // Target model for the default instance: ack N cycles after the request rises.
    always @(negedge clk) begin
        if (m_rd || m_wr) begin
            ack_cnt = ack_cnt + 1;
            ack_auto = ((m_rd && ack_cnt == rd_dly) || (m_wr && ack_cnt == wr_dly));
        end else begin
            ack_cnt  = 0;
            ack_auto = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!m_nwait)        nw_lo_seen  = 1'b1;
            if (m_wr && !m_nwait) nw_lo_in_wr = 1'b1;
            if (m_wr && m_rd)    both_seen   = 1'b1;
            if (m_wr)            wr_len      = wr_len + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return m_rd;
            1:       return m_wr;
            default: return t_rd;
        endcase
    endfunction

    function automatic logic nw(input int which);
        return (which < 2) ? m_nwait : t_nwait;
    endfunction

    task automatic wait_hi(input int which, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts samples (starting with the current one) while the request is high.
    task automatic hold_len(input int which, output int len, output int nwlo);
        len  = 0;
        nwlo = 0;
        while (sig(which) && len < 500) begin
            len++;
            if (!nw(which)) nwlo++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len, nwlo, rd_seen;

        rst_n = 1'b0; ne1 = 1'b1; noe = 1'b1; nwe = 1'b1;
        a = '0; din = '0; rdata_val = '0; err_clr = 1'b0; ack_force = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nwait", 32'(m_nwait), 32'd1);
        check("rst_dout",  m_dout, 32'd0);
        check("rst_addr",  32'(m_addr), 32'd0);
        check("rst_wdata", m_wdata, 32'd0);
        check("rst_rd",    32'(m_rd), 32'd0);
        check("rst_wr",    32'(m_wr), 32'd0);
        check("rst_err",   32'(m_err), 32'd0);
        check("rst_doe",   32'(m_doe), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // single read
        rd_dly = 3; rdata_val = 32'hCAFE_F00D; a = 26'h000_0123;
        ne1 = 1'b0; noe = 1'b0;
        wait_hi(0, 20, ok);
        check("rd1_start", 32'(ok), 32'd1);
        check("rd1_addr", 32'(m_addr), 32'h0000_0123);
        hold_len(0, len, nwlo);
        check("rd1_rd_len", len, 32'd3);
        check("rd1_nwait_lo_len", nwlo, 32'd3);
        check("rd1_nwait_after", 32'(m_nwait), 32'd1);
        check("rd1_dout", m_dout, 32'hCAFE_F00D);
        check("rd1_doe_on", 32'(m_doe), 32'd1);
        noe = 1'b1;
        #1;
        check("rd1_doe_off", 32'(m_doe), 32'd0);
        @(negedge clk);
        ne1 = 1'b1;
        repeat (6) @(negedge clk);

        // single posted write; last captured data must win
        wr_dly = 2; a = 26'h3FF_FFFF; din = 32'h1111_1111;
        nw_lo_seen = 1'b0; mon_en = 1'b1;
        ne1 = 1'b0; nwe = 1'b0;
        repeat (2) @(negedge clk);
        din = 32'hA5A5_A5A5;
        repeat (3) @(negedge clk);
        nwe = 1'b1;
        wait_hi(1, 20, ok);
        check("wr1_start", 32'(ok), 32'd1);
        check("wr1_addr", 32'(m_addr), 32'h03FF_FFFF);
        check("wr1_wdata", m_wdata, 32'hA5A5_A5A5);
        hold_len(1, len, nwlo);
        check("wr1_wr_len", len, 32'd2);
        ne1 = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("wr1_nwait_stayed_hi", 32'(nw_lo_seen), 32'd0);
        repeat (4) @(negedge clk);

        // read timeout on the 8-cycle instance
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_pre_clear", 32'(t_err), 32'd0);
        rd_dly = 3; rdata_val = 32'h0000_0001; a = 26'h000_0055;
        ne1 = 1'b0; noe = 1'b0;
        wait_hi(2, 20, ok);
        check("to1_start", 32'(ok), 32'd1);
        hold_len(2, len, nwlo);
        check("to1_rd_len", len, 32'd8);
        check("to1_dout", t_dout, 32'hDEAD_BEEF);
        check("to1_err", 32'(t_err), 32'd1);
        check("to1_nwait", 32'(t_nwait), 32'd1);
        noe = 1'b1; ne1 = 1'b1;
        repeat (5) @(negedge clk);
        check("to1_sticky", 32'(t_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to1_cleared", 32'(t_err), 32'd0);
        ne1 = 1'b0; noe = 1'b0;
        wait_hi(2, 20, ok);
        check("to2_start", 32'(ok), 32'd1);
        repeat (7) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to2_rd_dropped", 32'(t_rd), 32'd0);
        check("to2_set_wins", 32'(t_err), 32'd1);
        noe = 1'b1; ne1 = 1'b1;
        repeat (6) @(negedge clk);

        // write then read under one ne1, slow write ack
        wr_dly = 20; rd_dly = 3; rdata_val = 32'h5EED_1234;
        nw_lo_in_wr = 1'b0; both_seen = 1'b0; wr_len = 0; mon_en = 1'b1;
        a = 26'h000_0040; din = 32'h1234_5678;
        ne1 = 1'b0; nwe = 1'b0;
        repeat (3) @(negedge clk);
        nwe = 1'b1;
        repeat (3) @(negedge clk);
        a = 26'h000_0080; noe = 1'b0;
        wait_hi(1, 20, ok);
        check("wr2_start", 32'(ok), 32'd1);
        check("wr2_addr", 32'(m_addr), 32'h0000_0040);
        check("wr2_wdata", m_wdata, 32'h1234_5678);
        wait_hi(0, 60, ok);
        check("rd2_start", 32'(ok), 32'd1);
        check("rd2_wr_done", 32'(m_wr), 32'd0);
        check("rd2_addr", 32'(m_addr), 32'h0000_0080);
        hold_len(0, len, nwlo);
        check("rd2_rd_len", len, 32'd3);
        check("rd2_dout", m_dout, 32'h5EED_1234);
        check("rd2_doe", 32'(m_doe), 32'd1);
        mon_en = 1'b0;
        check("wr2_wr_len", wr_len, 32'd20);
        check("wr2_nwait_lo_on_strobe", 32'(nw_lo_in_wr), 32'd1);
        check("wr2_no_overlap", 32'(both_seen), 32'd0);
        noe = 1'b1; ne1 = 1'b1;
        repeat (6) @(negedge clk);

        // reset in the middle of a read, strobes left low
        rd_dly = 50; a = 26'h000_0077;
        ne1 = 1'b0; noe = 1'b0;
        wait_hi(0, 20, ok);
        check("rr_start", 32'(ok), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_rd", 32'(m_rd), 32'd0);
        check("rr_nwait", 32'(m_nwait), 32'd1);
        check("rr_addr", 32'(m_addr), 32'd0);
        check("rr_dout", m_dout, 32'd0);
        check("rr_doe", 32'(m_doe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_rd || !m_nwait) rd_seen++;
        end
        check("rr_no_req_in_resync", rd_seen, 32'd0);
        ne1 = 1'b1; noe = 1'b1;
        repeat (4) @(negedge clk);
        rd_dly = 3; rdata_val = 32'h600D_CAFE; a = 26'h000_0099;
        ne1 = 1'b0; noe = 1'b0;
        wait_hi(0, 20, ok);
        check("rr_read_start", 32'(ok), 32'd1);
        check("rr_read_addr", 32'(m_addr), 32'h0000_0099);
        hold_len(0, len, nwlo);
        check("rr_read_len", len, 32'd3);
        check("rr_read_dout", m_dout, 32'h600D_CAFE);
        noe = 1'b1; ne1 = 1'b1;
        repeat (6) @(negedge clk);

        // spurious ack in IDLE while both strobes go low: read must win
        rd_dly = 4; rdata_val = 32'h0F0F_0F0F; a = 26'h000_01AB;
        ne1 = 1'b0; noe = 1'b0; nwe = 1'b0; ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        check("sp_rd_issued", 32'(m_rd), 32'd1);
        check("sp_no_wr", 32'(m_wr), 32'd0);
        check("sp_addr", 32'(m_addr), 32'h0000_01AB);
        hold_len(0, len, nwlo);
        check("sp_rd_len", len, 32'd4);
        check("sp_dout", m_dout, 32'h0F0F_0F0F);
        noe = 1'b1; nwe = 1'b1; ne1 = 1'b1;
        repeat (6) @(negedge clk);
        check("sp_final_wr", 32'(m_wr), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
